// File: rtl/mult_div_unit_pkg.sv
// ---------------------------------------------------------------------------
// mult_div_unit_pkg
//   Shared definitions for the iterative signed multiply/divide unit:
//   default operand width, MDCtrl operation encodings and the FSM state type.
//   No ports; imported by the interface and the unit itself.
// ---------------------------------------------------------------------------
package mult_div_unit_pkg;

    // Default operand width.
    // The product and the quotient/remainder pair are split over hi/lo.
    localparam int MD_WIDTH = 32;

    // MDCtrl operation select
    localparam logic MD_MULT = 1'b0;
    localparam logic MD_DIV  = 1'b1;

    // Sequencer states: IDLE -> RUN -> FIX -> DONE -> IDLE
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// ---------------------------------------------------------------------------
// mult_div_unit_if
//   Bundle between the multicycle control FSM (master) and the
//   multiply/divide unit (slave).
//   Signals:
//     start   master->slave  level request, only looked at while the unit is idle
//     md_sel  master->slave  0 = MULT, 1 = DIV
//     op_a    master->slave  rs: multiplicand / dividend
//     op_b    master->slave  rt: multiplier / divisor
//     hi      slave->master  MULT: upper product half; DIV: remainder
//     lo      slave->master  MULT: lower product half; DIV: quotient
//     busy    slave->master  an operation is in flight
//     done    slave->master  one-cycle pulse; hi/lo valid from that cycle
//     div0    slave->master  combinational divide-by-zero flag
// ---------------------------------------------------------------------------
interface mult_div_unit_if
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) ();

    logic             start;
    logic             md_sel;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div0;

    modport master (
        output start, md_sel, op_a, op_b,
        input  hi, lo, busy, done, div0
    );

    modport slave (
        input  start, md_sel, op_a, op_b,
        output hi, lo, busy, done, div0
    );

endinterface

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Iterative signed multiply/divide unit that sits behind the multicycle
//   control FSM.
//   - MULT uses a shift-add multiplier.
//   - DIV uses a restoring divider.
//   Both work on operand magnitudes. A final FIX cycle applies the sign
//   correction and loads hi/lo.
//   Ports:
//     clk    in     rising-edge clock
//     reset  in     asynchronous, active-high
//     bus    slave  start/md_sel/op_a/op_b in;
//                   hi/lo/busy/done/div0 out
//   Timing:
//     - A start sampled at edge 0 gives done high after edge WIDTH+2.
//     - busy and done are registered from the current state, so they lag
//       the state register by one cycle.
//     - hi/lo are loaded on the FIX->DONE edge, so they are already stable
//       when done is seen.
// ---------------------------------------------------------------------------
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    md_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // acc: upper product half (MULT) or partial remainder (DIV)
    logic [WIDTH-1:0] acc_q, acc_d;
    // low: multiplier/lower product (MULT) or dividend/quotient (DIV)
    logic [WIDTH-1:0] low_q, low_d;
    // opnd: multiplicand (MULT) or divisor (DIV) magnitude
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic             sel_q, sel_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             div0;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   mult_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic             div_ok;
    logic               neg_result;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] product_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // The control FSM samples div0 in the same cycle it raises start.
    // So div0 is purely combinational and is not affected by reset.
    assign div0 = (bus.md_sel == MD_DIV) && (bus.op_b == '0);

    // Operand magnitudes.
    // The magnitude of the most negative value is 2^(WIDTH-1) when read as
    // an unsigned number, so no extra bit is needed.
    assign mag_a = bus.op_a[WIDTH-1] ? -bus.op_a : bus.op_a;
    assign mag_b = bus.op_b[WIDTH-1] ? -bus.op_b : bus.op_b;

    // Shift-add step: the carry out of the add becomes the new top bit of
    // the {acc,low} register after the right shift.
    assign mult_sum = {1'b0, acc_q} + (low_q[0] ? {1'b0, opnd_q} : '0);

    // Restoring-divide step.
    // - The partial remainder is always below the divisor magnitude, which
    //   is at most 2^(WIDTH-1). So the shifted remainder fits in WIDTH bits.
    // - The top bit of the WIDTH+1 bit trial is therefore a pure borrow.
    assign div_shift = {acc_q, low_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opnd_q};
    assign div_ok    = ~div_trial[WIDTH];

    // Sign correction applied in FIX.
    // - MULT negates the whole 2W product.
    // - DIV negates the quotient for unlike signs, and gives the remainder
    //   the sign of the dividend.
    assign neg_result  = sign_a_q ^ sign_b_q;
    assign product     = {acc_q, low_q};
    assign product_fix = neg_result ? -product : product;
    assign quo_fix     = neg_result ? -low_q : low_q;
    assign rem_fix     = sign_a_q ? -acc_q : acc_q;

    // Next-state and datapath update.
    // Everything holds by default; each state only overrides what it owns.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        low_d    = low_q;
        opnd_d   = opnd_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        sel_d    = sel_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = (state_q != ST_IDLE);
        done_d   = (state_q == ST_DONE);

        case (state_q)
            ST_IDLE: begin
                // A divide by zero is refused here.
                // The control FSM handles it through its exception path.
                if (bus.start && !div0) begin
                    sel_d    = bus.md_sel;
                    sign_a_d = bus.op_a[WIDTH-1];
                    sign_b_d = bus.op_b[WIDTH-1];
                    acc_d    = '0;
                    cnt_d    = '0;
                    if (bus.md_sel == MD_MULT) begin
                        low_d  = mag_b;
                        opnd_d = mag_a;
                    end else begin
                        low_d  = mag_a;
                        opnd_d = mag_b;
                    end
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (sel_q == MD_MULT) begin
                    acc_d = mult_sum[WIDTH:1];
                    low_d = {mult_sum[0], low_q[WIDTH-1:1]};
                end else begin
                    acc_d = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
                    low_d = {low_q[WIDTH-2:0], div_ok};
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_FIX: begin
                if (sel_q == MD_MULT) begin
                    hi_d = product_fix[2*WIDTH-1:WIDTH];
                    lo_d = product_fix[WIDTH-1:0];
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                state_d = ST_DONE;
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers.
    // An asynchronous reset aborts any operation in flight: hi/lo are
    // cleared and no done pulse is produced.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            low_q    <= '0;
            opnd_q   <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            sel_q    <= MD_MULT;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            low_q    <= low_d;
            opnd_q   <= opnd_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            sel_q    <= sel_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.div0 = div0;

endmodule
